// File: rtl/text_pkg.sv
// Shared constants, FSM state encoding and screen geometry for the PS/2 text writer.
package text_pkg;

   localparam int unsigned TEXT_COLS = 64;
   localparam int unsigned TEXT_ROWS = 30;

   localparam logic [7:0] SC_BREAK   = 8'hF0;
   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_LSHIFT  = 8'h12;
   localparam logic [7:0] SC_RSHIFT  = 8'h59;
   localparam logic [7:0] SC_ENTER   = 8'h5A;
   localparam logic [7:0] SC_BKSP    = 8'h66;
   localparam logic [7:0] SC_SPACE   = 8'h29;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_BREAK     = 3'd1,
      ST_EXT       = 3'd2,
      ST_EXT_BREAK = 3'd3,
      ST_WRITE     = 3'd4,
      ST_CLEAR     = 3'd5
   } state_e;

   function automatic logic is_shift_code(input logic [7:0] sc);
      return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/ps2_scancode_ascii.sv
// Combinational PS/2 set-2 make code to ASCII lookup for letters, digit row and space.
module ps2_scancode_ascii
   import text_pkg::*;
(
   input  logic [7:0] scancode,
   input  logic       shift,
   output logic [7:0] ascii,
   output logic       hit
);

   logic [7:0] base_s;

   function automatic logic [7:0] shifted_digit(input logic [7:0] d);
      logic [7:0] r;
      case (d)
         8'h30:   r = 8'h29;
         8'h31:   r = 8'h21;
         8'h32:   r = 8'h40;
         8'h33:   r = 8'h23;
         8'h34:   r = 8'h24;
         8'h35:   r = 8'h25;
         8'h36:   r = 8'h5E;
         8'h37:   r = 8'h26;
         8'h38:   r = 8'h2A;
         8'h39:   r = 8'h28;
         default: r = d;
      endcase
      return r;
   endfunction

   // Unshifted character for each mapped make code.
   always_comb begin
      hit    = 1'b1;
      base_s = 8'h00;
      case (scancode)
         8'h1C: base_s = 8'h61;
         8'h32: base_s = 8'h62;
         8'h21: base_s = 8'h63;
         8'h23: base_s = 8'h64;
         8'h24: base_s = 8'h65;
         8'h2B: base_s = 8'h66;
         8'h34: base_s = 8'h67;
         8'h33: base_s = 8'h68;
         8'h43: base_s = 8'h69;
         8'h3B: base_s = 8'h6A;
         8'h42: base_s = 8'h6B;
         8'h4B: base_s = 8'h6C;
         8'h3A: base_s = 8'h6D;
         8'h31: base_s = 8'h6E;
         8'h44: base_s = 8'h6F;
         8'h4D: base_s = 8'h70;
         8'h15: base_s = 8'h71;
         8'h2D: base_s = 8'h72;
         8'h1B: base_s = 8'h73;
         8'h2C: base_s = 8'h74;
         8'h3C: base_s = 8'h75;
         8'h2A: base_s = 8'h76;
         8'h1D: base_s = 8'h77;
         8'h22: base_s = 8'h78;
         8'h35: base_s = 8'h79;
         8'h1A: base_s = 8'h7A;
         8'h45: base_s = 8'h30;
         8'h16: base_s = 8'h31;
         8'h1E: base_s = 8'h32;
         8'h26: base_s = 8'h33;
         8'h25: base_s = 8'h34;
         8'h2E: base_s = 8'h35;
         8'h36: base_s = 8'h36;
         8'h3D: base_s = 8'h37;
         8'h3E: base_s = 8'h38;
         8'h46: base_s = 8'h39;
         SC_SPACE: base_s = ASCII_SPACE;
         default: begin
            base_s = 8'h00;
            hit    = 1'b0;
         end
      endcase
   end

   // Shift only affects letters and the digit row.
   always_comb begin
      if (shift && (base_s >= 8'h61) && (base_s <= 8'h7A)) begin
         ascii = base_s - 8'h20;
      end else if (shift && (base_s >= 8'h30) && (base_s <= 8'h39)) begin
         ascii = shifted_digit(base_s);
      end else begin
         ascii = base_s;
      end
   end

endmodule

// File: rtl/ps2_text_writer.sv
// Turns PS/2 scancodes into character-buffer writes with a wrapping cursor.
// Optional power-up screen clear is compiled in with TEXT_WRITER_CLEAR_EN.
module ps2_text_writer
   import text_pkg::*;
#(
   parameter int unsigned COLS = TEXT_COLS,
   parameter int unsigned ROWS = TEXT_ROWS
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  kbd_data,
   input  logic        kbd_valid,
   output logic        kbd_ready,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic [5:0]  cursor_col,
   output logic [5:0]  cursor_row,
   output logic [7:0]  char_count
);

   localparam logic [5:0] COL_LAST = 6'(COLS - 1);
   localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

`ifdef TEXT_WRITER_CLEAR_EN
   localparam state_e RESET_STATE = ST_CLEAR;
   localparam logic   RESET_READY = 1'b0;
`else
   localparam state_e RESET_STATE = ST_IDLE;
   localparam logic   RESET_READY = 1'b1;
`endif

   state_e      state_q, state_d;
   logic        shift_q, shift_d;
   logic        bksp_q, bksp_d;
   logic [5:0]  col_q, col_d;
   logic [5:0]  row_q, row_d;
   logic [7:0]  count_q, count_d;
   logic        mem_we_q, mem_we_d;
   logic [11:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        kbd_ready_q, kbd_ready_d;
`ifdef TEXT_WRITER_CLEAR_EN
   logic        clr_done_q, clr_done_d;
`endif

   logic [7:0]  ascii_s;
   logic        hit_s;
   logic        accept_s;
   logic [5:0]  row_inc_s, adv_col_s, adv_row_s, back_col_s, back_row_s;

   ps2_scancode_ascii u_lookup (
      .scancode (kbd_data),
      .shift    (shift_q),
      .ascii    (ascii_s),
      .hit      (hit_s)
   );

   assign accept_s  = kbd_valid && kbd_ready_q;
   assign row_inc_s = (row_q == ROW_LAST) ? 6'd0 : row_q + 6'd1;
   assign adv_col_s = (col_q == COL_LAST) ? 6'd0 : col_q + 6'd1;
   assign adv_row_s = (col_q == COL_LAST) ? row_inc_s : row_q;

   // Backspace target: previous cell, pinned at the top-left corner.
   always_comb begin
      if (col_q != 6'd0) begin
         back_col_s = col_q - 6'd1;
         back_row_s = row_q;
      end else if (row_q != 6'd0) begin
         back_col_s = COL_LAST;
         back_row_s = row_q - 6'd1;
      end else begin
         back_col_s = 6'd0;
         back_row_s = 6'd0;
      end
   end

   // Next-state logic for the prefix tracker, cursor and write port.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bksp_d      = bksp_q;
      col_d       = col_q;
      row_d       = row_q;
      count_d     = count_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef TEXT_WRITER_CLEAR_EN
      clr_done_d  = clr_done_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!accept_s) begin
               state_d = ST_IDLE;
            end else if (kbd_data == SC_BREAK) begin
               state_d = ST_BREAK;
            end else if (kbd_data == SC_EXT) begin
               state_d = ST_EXT;
            end else if (is_shift_code(kbd_data)) begin
               shift_d = 1'b1;
            end else if (kbd_data == SC_ENTER) begin
               col_d = 6'd0;
               row_d = row_inc_s;
            end else if (kbd_data == SC_BKSP) begin
               // Cursor moves now so the blanking write lands on the new cell.
               col_d       = back_col_s;
               row_d       = back_row_s;
               mem_we_d    = 1'b1;
               mem_addr_d  = {back_col_s, back_row_s};
               mem_wdata_d = ASCII_SPACE;
               bksp_d      = 1'b1;
               state_d     = ST_WRITE;
            end else if (hit_s) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = {col_q, row_q};
               mem_wdata_d = ascii_s;
               bksp_d      = 1'b0;
               state_d     = ST_WRITE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BREAK: begin
            if (accept_s) begin
               if (is_shift_code(kbd_data)) begin
                  shift_d = 1'b0;
               end else begin
                  shift_d = shift_q;
               end
               state_d = ST_IDLE;
            end else begin
               state_d = ST_BREAK;
            end
         end
         ST_EXT: begin
            if (accept_s) begin
               state_d = (kbd_data == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
            end else begin
               state_d = ST_EXT;
            end
         end
         ST_EXT_BREAK: begin
            if (accept_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_EXT_BREAK;
            end
         end
         ST_WRITE: begin
            if (!bksp_q) begin
               col_d   = adv_col_s;
               row_d   = adv_row_s;
               count_d = count_q + 8'd1;
            end else begin
               col_d = col_q;
            end
            state_d = ST_IDLE;
         end
`ifdef TEXT_WRITER_CLEAR_EN
         ST_CLEAR: begin
            // The cursor doubles as the sweep pointer; it wraps back to (0,0) at the end.
            if (clr_done_q) begin
               clr_done_d = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               mem_we_d    = 1'b1;
               mem_addr_d  = {col_q, row_q};
               mem_wdata_d = ASCII_SPACE;
               col_d       = adv_col_s;
               row_d       = adv_row_s;
               clr_done_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      kbd_ready_d = (state_d == ST_IDLE) || (state_d == ST_BREAK) ||
                    (state_d == ST_EXT)  || (state_d == ST_EXT_BREAK);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RESET_STATE;
         shift_q     <= 1'b0;
         bksp_q      <= 1'b0;
         col_q       <= 6'd0;
         row_q       <= 6'd0;
         count_q     <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 12'd0;
         mem_wdata_q <= ASCII_SPACE;
         kbd_ready_q <= RESET_READY;
`ifdef TEXT_WRITER_CLEAR_EN
         clr_done_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bksp_q      <= bksp_d;
         col_q       <= col_d;
         row_q       <= row_d;
         count_q     <= count_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         kbd_ready_q <= kbd_ready_d;
`ifdef TEXT_WRITER_CLEAR_EN
         clr_done_q  <= clr_done_d;
`endif
      end
   end

   assign kbd_ready  = kbd_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign char_count = count_q;

endmodule

// File: tb/tb_ps2_text_writer.sv
// Directed self-checking bench for ps2_text_writer (default 64x30 geometry).
module tb_ps2_text_writer;

   logic        clk;
   logic        rst;
   logic [7:0]  kbd_data;
   logic        kbd_valid;
   logic        kbd_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [5:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic [7:0]  char_count;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int we_while_ready = 0;

   logic [11:0] wq_addr[$];
   logic [7:0]  wq_data[$];
   int          acc_cyc[$];

   ps2_text_writer dut (
      .clk        (clk),
      .rst        (rst),
      .kbd_data   (kbd_data),
      .kbd_valid  (kbd_valid),
      .kbd_ready  (kbd_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .char_count (char_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log every write strobe and every handshake that will complete at the next edge.
   always @(negedge clk) begin
      if (mem_we) begin
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_wdata);
         if (kbd_ready) we_while_ready = we_while_ready + 1;
      end
      if (kbd_valid && kbd_ready && !rst) acc_cyc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] addr_of(input int col, input int row);
      return {6'(col), 6'(row)};
   endfunction

   task automatic chk_wr(input string tag, input int idx, input logic [11:0] ea, input logic [7:0] ed);
      if (idx < wq_addr.size()) begin
         chk({tag, "_addr"}, 32'(wq_addr[idx]), 32'(ea));
         chk({tag, "_data"}, 32'(wq_data[idx]), 32'(ed));
      end else begin
         chk({tag, "_missing"}, 32'(wq_addr.size()), 32'(idx + 1));
      end
   endtask

   task automatic clear_logs();
      wq_addr.delete();
      wq_data.delete();
      acc_cyc.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one byte and wait (bounded) for the handshake; optionally keep valid high.
   task automatic send(input logic [7:0] b, input bit hold);
      int n;
      kbd_data  = b;
      kbd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!kbd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!kbd_ready) chk("send_timeout", 32'(kbd_ready), 32'd1);
      @(posedge clk);
      #1;
      if (!hold) kbd_valid = 1'b0;
   endtask

   task automatic do_reset();
      int n;
      rst       = 1'b1;
      kbd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef TEXT_WRITER_CLEAR_EN
      n = 0;
      while (!kbd_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!kbd_ready) chk("clear_timeout", 32'(kbd_ready), 32'd1);
      @(posedge clk);
      #1;
`else
      n = 0;
`endif
      clear_logs();
   endtask

   initial begin
      int base;
      int bad_order;
      rst       = 1'b1;
      kbd_valid = 1'b0;
      kbd_data  = 8'h00;

      // Reset values, observed while reset is held.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we",    32'(mem_we),     32'd0);
      chk("rst_addr",  32'(mem_addr),   32'd0);
      chk("rst_wdata", 32'(mem_wdata),  32'h20);
      chk("rst_col",   32'(cursor_col), 32'd0);
      chk("rst_row",   32'(cursor_row), 32'd0);
      chk("rst_count", 32'(char_count), 32'd0);
`ifdef TEXT_WRITER_CLEAR_EN
      chk("rst_ready", 32'(kbd_ready),  32'd0);

      // Full sweep after reset.
      rst = 1'b0;
      clear_logs();
      base = 0;
      while (!kbd_ready && base < 3000) begin
         @(negedge clk);
         base++;
      end
      chk("clr_size", 32'(wq_addr.size()), 32'd1920);
      bad_order = 0;
      for (int i = 0; i < wq_addr.size(); i++) begin
         if (wq_addr[i] !== addr_of(i % 64, i / 64) || wq_data[i] !== 8'h20) bad_order++;
      end
      chk("clr_order", 32'(bad_order), 32'd0);

      // Reset mid-sweep restarts from (0,0).
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      wait_cycles(100);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      clear_logs();
      base = 0;
      while (!kbd_ready && base < 3000) begin
         @(negedge clk);
         base++;
      end
      chk("clr2_size", 32'(wq_addr.size()), 32'd1920);
      chk_wr("clr2_first", 0, 12'h000, 8'h20);
      chk_wr("clr2_last", 1919, addr_of(63, 29), 8'h20);
`else
      chk("rst_ready", 32'(kbd_ready),  32'd1);
`endif

      // Single key: latency and cursor advance one edge later.
      do_reset();
      send(8'h1C, 1'b0);
      chk("k1_we",    32'(mem_we),     32'd1);
      chk("k1_addr",  32'(mem_addr),   32'h000);
      chk("k1_wdata", 32'(mem_wdata),  32'h61);
      chk("k1_col0",  32'(cursor_col), 32'd0);
      wait_cycles(1);
      chk("k1_we_off", 32'(mem_we),     32'd0);
      chk("k1_col",    32'(cursor_col), 32'd1);
      chk("k1_count",  32'(char_count), 32'd1);

      // Shift make/break around letters, shifted digit, space, unmapped key.
      do_reset();
      send(8'h12, 1'b0); send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
      send(8'hF0, 1'b0); send(8'h12, 1'b0); send(8'h1C, 1'b0);
      send(8'h59, 1'b0); send(8'h1A, 1'b0); send(8'h16, 1'b0); send(8'h29, 1'b0);
      send(8'hF0, 1'b0); send(8'h59, 1'b0); send(8'h45, 1'b0); send(8'h76, 1'b0);
      wait_cycles(3);
      chk("sh_nwr", 32'(wq_addr.size()), 32'd6);
      chk_wr("sh_A",     0, addr_of(0, 0), 8'h41);
      chk_wr("sh_a",     1, addr_of(1, 0), 8'h61);
      chk_wr("sh_Z",     2, addr_of(2, 0), 8'h5A);
      chk_wr("sh_bang",  3, addr_of(3, 0), 8'h21);
      chk_wr("sh_space", 4, addr_of(4, 0), 8'h20);
      chk_wr("sh_zero",  5, addr_of(5, 0), 8'h30);
      chk("sh_count", 32'(char_count), 32'd6);
      chk("sh_col",   32'(cursor_col), 32'd6);

      // Row wrap on a full line, then Enter wrapping from the last row.
      do_reset();
      for (int i = 0; i < 64; i++) send(8'h1C, 1'b0);
      wait_cycles(2);
      chk("ln_nwr", 32'(wq_addr.size()), 32'd64);
      chk_wr("ln_last", 63, addr_of(63, 0), 8'h61);
      chk("ln_col",   32'(cursor_col), 32'd0);
      chk("ln_row",   32'(cursor_row), 32'd1);
      chk("ln_count", 32'(char_count), 32'd64);
      for (int i = 0; i < 28; i++) send(8'h5A, 1'b0);
      chk("ent_row29", 32'(cursor_row), 32'd29);
      send(8'h5A, 1'b0);
      chk("ent_col",  32'(cursor_col), 32'd0);
      chk("ent_row",  32'(cursor_row), 32'd0);
      chk("ent_nwr",  32'(wq_addr.size()), 32'd64);

      // Backspace at the origin, across a row boundary, and mid-row.
      clear_logs();
      send(8'h66, 1'b0);
      wait_cycles(1);
      chk_wr("bs0", 0, addr_of(0, 0), 8'h20);
      chk("bs0_col", 32'(cursor_col), 32'd0);
      chk("bs0_row", 32'(cursor_row), 32'd0);
      send(8'h5A, 1'b0);
      send(8'h66, 1'b0);
      chk("bs1_col_now", 32'(cursor_col), 32'd63);
      wait_cycles(1);
      chk_wr("bs1", 1, addr_of(63, 0), 8'h20);
      chk("bs1_row", 32'(cursor_row), 32'd0);
      send(8'h66, 1'b0);
      wait_cycles(1);
      chk_wr("bs2", 2, addr_of(62, 0), 8'h20);
      chk("bs2_col",   32'(cursor_col), 32'd62);
      chk("bs_count",  32'(char_count), 32'd64);

      // Extended sequence with valid held high, then back-to-back keys.
      do_reset();
      send(8'hE0, 1'b1); send(8'h75, 1'b1); send(8'hE0, 1'b1); send(8'hF0, 1'b1);
      send(8'h75, 1'b1); send(8'h16, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b0);
      wait_cycles(3);
      chk("ex_nacc", 32'(acc_cyc.size()), 32'd8);
      if (acc_cyc.size() == 8) begin
         chk("ex_prefix_rate", 32'(acc_cyc[5] - acc_cyc[0]), 32'd5);
         chk("ex_key_gap1",    32'(acc_cyc[6] - acc_cyc[5]), 32'd2);
         chk("ex_key_gap2",    32'(acc_cyc[7] - acc_cyc[6]), 32'd2);
      end
      chk("ex_nwr", 32'(wq_addr.size()), 32'd3);
      chk_wr("ex_one", 0, addr_of(0, 0), 8'h31);
      chk_wr("ex_a1",  1, addr_of(1, 0), 8'h61);
      chk_wr("ex_a2",  2, addr_of(2, 0), 8'h61);

      // Reset coinciding with the accepting edge suppresses the write.
      do_reset();
      @(negedge clk);
      kbd_data  = 8'h1C;
      kbd_valid = 1'b1;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      chk("rw_we",  32'(mem_we),     32'd0);
      chk("rw_col", 32'(cursor_col), 32'd0);
      kbd_valid = 1'b0;
      do_reset();

      chk("we_vs_ready", 32'(we_while_ready), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
